// File: rtl/mem_arb.sv
// mem_arb: shares the single-ported mem between master A (cpu) and master B.
// Define MEMARB_RR_EN for round-robin ties; otherwise A has fixed priority.
module mem_arb #(
  parameter int ABITS = 9,
  parameter int DBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_rd,
  input  logic             a_wr,
  input  logic [ABITS-1:0] a_addr,
  input  logic [DBITS-1:0] a_wdata,
  output logic [DBITS-1:0] a_rdata,
  output logic             a_wait,
  input  logic             b_rd,
  input  logic             b_wr,
  input  logic [ABITS-1:0] b_addr,
  input  logic [DBITS-1:0] b_wdata,
  output logic [DBITS-1:0] b_rdata,
  output logic             b_wait,
  output logic             memrd,
  output logic             memwr,
  output logic [ABITS-1:0] memaddr,
  output logic [DBITS-1:0] memwdata,
  input  logic             memwait,
  input  logic [DBITS-1:0] memrdata,
  output logic [1:0]       owner
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_A = 2'b01;
  localparam logic [1:0] OWN_B = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       a_req;
  logic       b_req;
  logic       own_a;
  logic       own_b;
  logic       tie_b;
  logic       win_b;

  assign a_req = a_rd | a_wr;
  assign b_req = b_rd | b_wr;

  // reset masks ownership so a pending requester stalls at once
  assign own_a = (state == OWN_A) & ~rst;
  assign own_b = (state == OWN_B) & ~rst;

  assign owner = state;

`ifdef MEMARB_RR_EN
  logic last;

  assign tie_b = ~last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && (a_req | b_req)) begin
      last <= win_b;
    end
  end
`else
  assign tie_b = 1'b0;
`endif

  assign win_b = b_req & (~a_req | tie_b);

  always_comb begin
    memrd    = 1'b0;
    memwr    = 1'b0;
    memaddr  = '0;
    memwdata = '0;
    unique case (1'b1)
      own_a: begin
        memrd    = a_rd & ~a_wr;
        memwr    = a_wr;
        memaddr  = a_addr;
        memwdata = a_wdata;
      end
      own_b: begin
        memrd    = b_rd & ~b_wr;
        memwr    = b_wr;
        memaddr  = b_addr;
        memwdata = b_wdata;
      end
      default: begin
      end
    endcase
  end

  assign a_wait  = own_a ? memwait : a_req;
  assign b_wait  = own_b ? memwait : b_req;
  assign a_rdata = own_a ? memrdata : '0;
  assign b_rdata = own_b ? memrdata : '0;

  // owned state ends on completion or on abort (request dropped)
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (a_req | b_req) begin
          state_nx = win_b ? OWN_B : OWN_A;
        end
      end
      OWN_A: begin
        if (!(a_req & memwait)) begin
          state_nx = IDLE;
        end
      end
      OWN_B: begin
        if (!(b_req & memwait)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed test-plan cases, then two random masters
// against a behavioural memory with a scoreboard monitor.
module tb_mem_arb;

`ifdef MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [8:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_wait, b_wait;
  logic        memrd, memwr, memwait;
  logic [8:0]  memaddr;
  logic [15:0] memwdata, memrdata;
  logic [1:0]  owner;

  logic        dir_wait = 1'b0;
  logic        rnd_wait = 1'b0;
  logic [15:0] dir_rdata = 16'h0;
  bit          rnd = 1'b0;
  logic [15:0] fmem [512];
  bit          fv [512];
  logic [15:0] refmem [int];
  txn_t        qa[$];
  txn_t        qb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_arb #(.ABITS(9), .DBITS(16)) dut (
    .clk(clk), .rst(rst),
    .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_wait(a_wait),
    .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_wait(b_wait),
    .memrd(memrd), .memwr(memwr), .memaddr(memaddr),
    .memwdata(memwdata), .memwait(memwait), .memrdata(memrdata),
    .owner(owner)
  );

  function automatic logic [15:0] seed_val(input logic [8:0] a);
    return {a[6:0], a} ^ 16'hA5C3;
  endfunction

  assign memwait  = rnd ? rnd_wait : dir_wait;
  assign memrdata = rnd ? (fv[memaddr] ? fmem[memaddr] : seed_val(memaddr))
                        : dir_rdata;

  always @(posedge clk) begin
    if (rnd && memwr && !memwait) begin
      fmem[memaddr] <= memwdata;
      fv[memaddr]   <= 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_wait = ($urandom_range(0, 2) == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_all;
    a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
    b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic master(input bit pb, input int n);
    for (int i = 0; i < n; i++) begin
      txn_t t;
      int   op;
      bit   done;
      op     = $urandom_range(0, 2);
      t.rd   = (op != 1);
      t.wr   = (op != 0);
      t.addr = 9'($urandom_range(0, 511));
      t.data = 16'($urandom_range(0, 65535));
      if (pb) begin
        qb.push_back(t);
        b_rd = t.rd; b_wr = t.wr; b_addr = t.addr; b_wdata = t.data;
      end else begin
        qa.push_back(t);
        a_rd = t.rd; a_wr = t.wr; a_addr = t.addr; a_wdata = t.data;
      end
      done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (pb ? !b_wait : !a_wait) done = 1;
      end
      if (!done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL master%0d_timeout: got no completion, expected one within 100 cycles", pb);
      end
      @(posedge clk);
      #1;
      if (pb) begin b_rd = 0; b_wr = 0; end
      else begin a_rd = 0; a_wr = 0; end
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  // scoreboard: predicts each grant from the requests seen in the
  // arbitration cycle, then checks the completing transfer
  bit prev_busy = 0, prev_a = 0, prev_b = 0;
  bit m_last = 1, exp_b = 0, chk_idle = 0;

  always @(negedge clk) begin
    if (rnd) begin
      bit   busy, ca, cb, tie_b;
      txn_t t;
      busy = memrd | memwr;
      ca   = (a_rd | a_wr) && !a_wait;
      cb   = (b_rd | b_wr) && !b_wait;
      if (chk_idle) begin
        chk("gap_idle", 32'(busy), 0);
        chk_idle = 0;
      end
      if (busy && !prev_busy) begin
        chk("grant_has_req", 32'(prev_a | prev_b), 1);
        tie_b  = RR && !m_last;
        exp_b  = prev_b && (!prev_a || tie_b);
        m_last = exp_b;
        chk("grant_owner", 32'(owner), exp_b ? 2 : 1);
      end
      if (ca || cb) begin
        chk("one_completer", 32'(ca && cb), 0);
        chk("winner", 32'(cb), 32'(exp_b));
        if ((cb ? qb.size() : qa.size()) == 0) begin
          chk("queue_nonempty", 0, 1);
        end else begin
          t = cb ? qb.pop_front() : qa.pop_front();
          chk("mem_rd", 32'(memrd), 32'(t.rd && !t.wr));
          chk("mem_wr", 32'(memwr), 32'(t.wr));
          chk("mem_addr", 32'(memaddr), 32'(t.addr));
          if (t.wr) begin
            chk("mem_wdata", 32'(memwdata), 32'(t.data));
            refmem[int'(t.addr)] = t.data;
          end else begin
            chk("rdata", 32'(cb ? b_rdata : a_rdata),
                refmem.exists(int'(t.addr)) ? 32'(refmem[int'(t.addr)])
                                            : 32'(seed_val(t.addr)));
          end
          chk("other_rdata", 32'(cb ? a_rdata : b_rdata), 0);
        end
        chk_idle = 1;
      end
      prev_busy = busy;
      prev_a    = a_rd | a_wr;
      prev_b    = b_rd | b_wr;
    end
  end

  initial begin
    idle_all();
    rst = 1;
    b_wr = 1;
    b_addr = 9'h003;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_b_wait", 32'(b_wait), 1);
    chk("rst_memwr", 32'(memwr), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_memaddr", 32'(memaddr), 0);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    cyc(); rst = 0; b_wr = 0; b_addr = 0;
    smp();

    // single read
    cyc(); a_rd = 1; a_addr = 9'h012; dir_rdata = 16'hBEEF;
    smp();
    chk("rd_wait_c0", 32'(a_wait), 1);
    chk("rd_memrd_c0", 32'(memrd), 0);
    cyc(); smp();
    chk("rd_memrd", 32'(memrd), 1);
    chk("rd_addr", 32'(memaddr), 32'h012);
    chk("rd_wait", 32'(a_wait), 0);
    chk("rd_rdata", 32'(a_rdata), 32'hBEEF);
    chk("rd_owner", 32'(owner), 1);
    cyc(); a_rd = 0; smp();
    chk("rd_idle", 32'(owner), 0);

    // write stalled by memwait for 3 cycles
    cyc(); b_wr = 1; b_addr = 9'h1FF; b_wdata = 16'h1234; dir_wait = 1;
    smp();
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      chk("st_wait", 32'(b_wait), 1);
      chk("st_memwr", 32'(memwr), 1);
      chk("st_addr", 32'(memaddr), 32'h1FF);
      chk("st_wdata", 32'(memwdata), 32'h1234);
    end
    cyc(); dir_wait = 0; smp();
    chk("st_done", 32'(b_wait), 0);
    chk("st_done_wr", 32'(memwr), 1);
    cyc(); b_wr = 0; smp();
    chk("st_idle", 32'(owner), 0);

    // contention: B arrives while A is stalled
    cyc(); a_rd = 1; a_addr = 9'h055; dir_wait = 1; smp();
    cyc(); smp();
    chk("ct_owner_a", 32'(owner), 1);
    cyc(); b_rd = 1; b_addr = 9'h0AA; dir_rdata = 16'h5A5A; smp();
    for (int i = 0; i < 2; i++) begin
      chk("ct_b_wait", 32'(b_wait), 1);
      chk("ct_addr", 32'(memaddr), 32'h055);
      cyc(); smp();
    end
    cyc(); dir_wait = 0; smp();
    chk("ct_a_done", 32'(a_wait), 0);
    cyc(); a_rd = 0; smp();
    chk("ct_idle", 32'(owner), 0);
    chk("ct_idle_bw", 32'(b_wait), 1);
    cyc(); smp();
    chk("ct_owner_b", 32'(owner), 2);
    chk("ct_addr_b", 32'(memaddr), 32'h0AA);
    chk("ct_b_done", 32'(b_wait), 0);
    chk("ct_b_rdata", 32'(b_rdata), 32'h5A5A);
    chk("ct_a_rdata", 32'(a_rdata), 0);
    cyc(); b_rd = 0; smp();

    // abort
    cyc(); a_rd = 1; a_addr = 9'h100; dir_wait = 1; smp();
    cyc(); smp();
    chk("ab_memrd", 32'(memrd), 1);
    cyc(); a_rd = 0; smp();
    cyc(); smp();
    chk("ab_owner", 32'(owner), 0);
    chk("ab_memrd0", 32'(memrd), 0);
    dir_wait = 0;

    // rd and wr together
    cyc(); a_rd = 1; a_wr = 1; a_addr = 9'h0F0; a_wdata = 16'hCAFE; smp();
    cyc(); smp();
    chk("rw_memwr", 32'(memwr), 1);
    chk("rw_memrd", 32'(memrd), 0);
    chk("rw_wdata", 32'(memwdata), 32'hCAFE);
    cyc(); a_rd = 0; a_wr = 0; smp();

    // reset mid-write, then a continuous tie
    cyc(); b_wr = 1; b_addr = 9'h033; b_wdata = 16'h0077; dir_wait = 1; smp();
    cyc(); smp();
    chk("rs_owner_b", 32'(owner), 2);
    chk("rs_memwr", 32'(memwr), 1);
    cyc(); rst = 1; smp();
    chk("rs_b_wait", 32'(b_wait), 1);
    cyc(); rst = 0; a_rd = 1; a_addr = 9'h044; dir_wait = 0; smp();
    chk("rs_owner", 32'(owner), 0);
    chk("rs_memwr0", 32'(memwr), 0);
    chk("rs_b_wait2", 32'(b_wait), 1);
    for (int g = 0; g < 4; g++) begin
      logic [1:0] eo;
      eo = (RR && (g % 2 == 1)) ? 2'd2 : 2'd1;
      cyc(); smp();
      chk("tie_owner", 32'(owner), 32'(eo));
      chk("tie_b_wait", 32'(b_wait), 32'(eo != 2'd2));
      cyc(); smp();
      chk("tie_idle", 32'(owner), 0);
    end
    cyc(); idle_all(); rst = 1;
    cyc(); rst = 0;
    smp();

    // random traffic
    cyc();
    rnd = 1;
    fork
      master(1'b0, 40);
      master(1'b1, 40);
    join
    repeat (10) cyc();
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);
    rnd = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
